// File: rtl/img_pkg.sv
// Shared image-pipeline constants and helpers for frame buffers and the window conv engine.
package img_pkg;

  localparam int unsigned IMG_WD_DEF   = 16;
  localparam int unsigned IMG_HT_DEF   = 16;
  localparam int unsigned PXL_BITS_DEF = 12;

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StDrain,
    StDone
  } conv_state_e;

  // Wide enough that a full window of extreme products can never overflow.
  function automatic int unsigned acc_bits(input int unsigned pxl_bits,
                                           input int unsigned coef_bits,
                                           input int unsigned taps);
    return pxl_bits + coef_bits + $clog2(taps);
  endfunction

  // Bit offset of row-major window entry [y][x] in a flattened vector.
  function automatic int unsigned flat_idx(input int unsigned y,
                                           input int unsigned x,
                                           input int unsigned win_wd,
                                           input int unsigned elem_bits);
    return (y * win_wd + x) * elem_bits;
  endfunction

endpackage

// File: rtl/win_mac.sv
// Combinational signed window multiply-accumulate with result narrowing.
// Define CONV_SAT_EN to saturate the result; otherwise it wraps to PXL_BITS.
module win_mac
  import img_pkg::*;
#(
  parameter int unsigned WIN_WD    = 3,
  parameter int unsigned WIN_HT    = 3,
  parameter int unsigned PXL_BITS  = 12,
  parameter int unsigned COEF_BITS = 4
) (
  input  logic        [WIN_HT*WIN_WD*PXL_BITS-1:0]  data_flat_i,
  input  logic        [WIN_HT*WIN_WD*COEF_BITS-1:0] coef_flat_i,
  output logic signed [PXL_BITS-1:0]                result_o
);

  localparam int unsigned Taps     = WIN_WD * WIN_HT;
  localparam int unsigned ProdBits = PXL_BITS + COEF_BITS;
  localparam int unsigned AccBits  = acc_bits(PXL_BITS, COEF_BITS, Taps);

  logic signed [PXL_BITS-1:0]  pxl;
  logic signed [COEF_BITS-1:0] coef;
  logic signed [ProdBits-1:0]  prod;
  logic signed [AccBits-1:0]   acc;

  always_comb begin
    pxl  = '0;
    coef = '0;
    prod = '0;
    acc  = '0;
    for (int unsigned y = 0; y < WIN_HT; y++) begin
      for (int unsigned x = 0; x < WIN_WD; x++) begin
        pxl  = data_flat_i[flat_idx(y, x, WIN_WD, PXL_BITS) +: PXL_BITS];
        coef = coef_flat_i[flat_idx(y, x, WIN_WD, COEF_BITS) +: COEF_BITS];
        prod = ProdBits'(pxl) * ProdBits'(coef);
        acc  = acc + AccBits'(prod);
      end
    end
  end

`ifdef CONV_SAT_EN
  localparam logic signed [AccBits-1:0] SatMax =
    {{(AccBits - PXL_BITS + 1){1'b0}}, {(PXL_BITS - 1){1'b1}}};
  localparam logic signed [AccBits-1:0] SatMin =
    {{(AccBits - PXL_BITS + 1){1'b1}}, {(PXL_BITS - 1){1'b0}}};

  always_comb begin
    if (acc > SatMax) begin
      result_o = SatMax[PXL_BITS-1:0];
    end else if (acc < SatMin) begin
      result_o = SatMin[PXL_BITS-1:0];
    end else begin
      result_o = acc[PXL_BITS-1:0];
    end
  end
`else
  assign result_o = acc[PXL_BITS-1:0];
`endif

endmodule

// File: rtl/win_conv_engine.sv
// Raster-scans the source frame buffer, convolves each window and writes the result.
// Narrowing behaviour follows CONV_SAT_EN inside win_mac.
module win_conv_engine
  import img_pkg::*;
#(
  parameter int unsigned IMG_WD     = IMG_WD_DEF,
  parameter int unsigned IMG_HT     = IMG_HT_DEF,
  parameter int unsigned COORD_BITS = 4,
  parameter int unsigned WIN_WD     = 3,
  parameter int unsigned WIN_HT     = 3,
  parameter int unsigned PXL_BITS   = PXL_BITS_DEF,
  parameter int unsigned COEF_BITS  = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                start_i,
  input  logic [WIN_HT*WIN_WD*COEF_BITS-1:0]  kernel_flat_i,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                rd_en_o,
  output logic [COORD_BITS-1:0]               rd_x_o,
  output logic [COORD_BITS-1:0]               rd_y_o,
  input  logic [WIN_HT*WIN_WD*PXL_BITS-1:0]   rd_data_flat_i,
  output logic                                wr_en_o,
  output logic [COORD_BITS-1:0]               wr_x_o,
  output logic [COORD_BITS-1:0]               wr_y_o,
  output logic [PXL_BITS-1:0]                 wr_data_pxl_o
);

  localparam logic [COORD_BITS-1:0] XLast = COORD_BITS'(IMG_WD - 1);
  localparam logic [COORD_BITS-1:0] YLast = COORD_BITS'(IMG_HT - 1);

  conv_state_e                state_q;
  logic                       done_q;
  logic                       rd_en_q;
  logic [COORD_BITS-1:0]      rd_x_q;
  logic [COORD_BITS-1:0]      rd_y_q;
  logic                       wr_en_q;
  logic [COORD_BITS-1:0]      wr_x_q;
  logic [COORD_BITS-1:0]      wr_y_q;
  logic signed [PXL_BITS-1:0] wr_data_q;
  logic signed [PXL_BITS-1:0] mac_res;

  win_mac #(
    .WIN_WD    (WIN_WD),
    .WIN_HT    (WIN_HT),
    .PXL_BITS  (PXL_BITS),
    .COEF_BITS (COEF_BITS)
  ) u_win_mac (
    .data_flat_i (rd_data_flat_i),
    .coef_flat_i (kernel_flat_i),
    .result_o    (mac_res)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_x_q    <= '0;
      rd_y_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_x_q    <= '0;
      wr_y_q    <= '0;
      wr_data_q <= '0;
    end else begin
      done_q  <= 1'b0;
      wr_en_q <= rd_en_q;
      // Buffer answers combinationally, so the product is captured with its read.
      if (rd_en_q) begin
        wr_x_q    <= rd_x_q;
        wr_y_q    <= rd_y_q;
        wr_data_q <= mac_res;
      end
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q <= StScan;
            rd_en_q <= 1'b1;
            rd_x_q  <= '0;
            rd_y_q  <= '0;
          end
        end
        StScan: begin
          if (rd_x_q == XLast && rd_y_q == YLast) begin
            state_q <= StDrain;
            rd_en_q <= 1'b0;
          end else if (rd_x_q == XLast) begin
            rd_x_q <= '0;
            rd_y_q <= rd_y_q + 1'b1;
          end else begin
            rd_x_q <= rd_x_q + 1'b1;
          end
        end
        StDrain: begin
          state_q <= StDone;
          done_q  <= 1'b1;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy_o        = (state_q != StIdle);
  assign done_o        = done_q;
  assign rd_en_o       = rd_en_q;
  assign rd_x_o        = rd_x_q;
  assign rd_y_o        = rd_y_q;
  assign wr_en_o       = wr_en_q;
  assign wr_x_o        = wr_x_q;
  assign wr_y_o        = wr_y_q;
  assign wr_data_pxl_o = wr_data_q;

endmodule

// File: tb/tb_win_conv_engine.sv
// Scoreboard bench for win_conv_engine on a 4x4 image with an edge-duplicating source model.
module tb_win_conv_engine;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int CB = 2;
  localparam int WW = 3;
  localparam int WH = 3;
  localparam int P  = 12;
  localparam int C  = 4;
  localparam int N  = W * H;

  typedef struct {
    int x;
    int y;
    int v;
  } exp_t;

  logic              clk_i   = 1'b0;
  logic              rst_ni  = 1'b0;
  logic              start_i = 1'b0;
  logic [WH*WW*C-1:0] kernel_flat = '0;
  logic [WH*WW*P-1:0] rd_data_flat;
  logic              busy, done, rd_en, wr_en;
  logic [CB-1:0]     rd_x, rd_y, wr_x, wr_y;
  logic [P-1:0]      wr_data;

  logic signed [P-1:0] img [H][W];
  int   kern [9];
  int   mode;
  int   checks = 0;
  int   errors = 0;
  exp_t sb [$];

  always #5 clk_i = ~clk_i;

  win_conv_engine #(
    .IMG_WD     (W),
    .IMG_HT     (H),
    .COORD_BITS (CB),
    .WIN_WD     (WW),
    .WIN_HT     (WH),
    .PXL_BITS   (P),
    .COEF_BITS  (C)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .kernel_flat_i  (kernel_flat),
    .busy_o         (busy),
    .done_o         (done),
    .rd_en_o        (rd_en),
    .rd_x_o         (rd_x),
    .rd_y_o         (rd_y),
    .rd_data_flat_i (rd_data_flat),
    .wr_en_o        (wr_en),
    .wr_x_o         (wr_x),
    .wr_y_o         (wr_y),
    .wr_data_pxl_o  (wr_data)
  );

  function automatic int clamp(input int v, input int lim);
    if (v < 0) return 0;
    if (v >= lim) return lim - 1;
    return v;
  endfunction

  // Source buffer: combinational window with edge duplication.
  always_comb begin
    rd_data_flat = '0;
    for (int dy = 0; dy < WH; dy++) begin
      for (int dx = 0; dx < WW; dx++) begin
        rd_data_flat[(dy*WW+dx)*P +: P] =
          img[clamp(int'(rd_y) + dy - 1, H)][clamp(int'(rd_x) + dx - 1, W)];
      end
    end
  end

  function automatic int exp_val(input int x, input int y);
    case (mode)
      1: return 4 * y + x;
      2: return 9;
      3: return (x == 1 || x == 2) ? 400 : 0;
      default: begin
`ifdef CONV_SAT_EN
        return 2047;
`else
        return 1985;
`endif
      end
    endcase
  endfunction

  task automatic load_image(input int m);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        case (m)
          1: img[y][x] = P'(4 * y + x);
          2: img[y][x] = P'(1);
          3: img[y][x] = (x < 2) ? P'(0) : P'(100);
          default: img[y][x] = P'(2047);
        endcase
      end
    end
  endtask

  task automatic load_kernel();
    for (int i = 0; i < 9; i++) kernel_flat[i*C +: C] = C'(kern[i]);
  endtask

  task automatic run_frame(input string name, input int restart_at, input int abort_at);
    int   n_rd = 0;
    int   n_wr = 0;
    int   n_done = 0;
    int   first_rd = -1;
    int   first_wr = -1;
    int   last_wr = -1;
    int   done_at = -1;
    exp_t e;
    sb.delete();
    @(negedge clk_i);
    start_i = 1'b1;
    for (int k = 1; k <= N + 6; k++) begin
      @(negedge clk_i);
      start_i = (k == restart_at);
      if (k == abort_at) begin
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({busy, done, rd_en, wr_en, rd_x, rd_y, wr_x, wr_y, wr_data} !== '0) begin
          errors++;
          $display("FAIL %s async_reset outputs got %h exp 0", name,
                   {busy, done, rd_en, wr_en, rd_x, rd_y, wr_x, wr_y, wr_data});
        end
        repeat (3) begin
          @(negedge clk_i);
          checks++;
          if ((busy | done | rd_en | wr_en) !== 1'b0) begin
            errors++;
            $display("FAIL %s in_reset activity got %b%b%b%b exp 0000", name,
                     busy, done, rd_en, wr_en);
          end
        end
        rst_ni  = 1'b1;
        start_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checks++;
        if ((busy | done | wr_en) !== 1'b0) begin
          errors++;
          $display("FAIL %s post_abort idle got %b%b%b exp 000", name, busy, done, wr_en);
        end
        return;
      end
      checks++;
      if (busy !== (k <= N + 2)) begin
        errors++;
        $display("FAIL %s busy cycle %0d got %b exp %b", name, k, busy, (k <= N + 2));
      end
      if (wr_en) begin
        if (first_wr < 0) first_wr = k;
        last_wr = k;
        n_wr++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s unexpected_write cycle %0d got 1 exp 0", name, k);
        end else begin
          e = sb.pop_front();
          if (int'(wr_x) !== e.x || int'(wr_y) !== e.y || int'($signed(wr_data)) !== e.v) begin
            errors++;
            $display("FAIL %s write got (%0d,%0d)=%0d exp (%0d,%0d)=%0d", name,
                     wr_x, wr_y, $signed(wr_data), e.x, e.y, e.v);
          end
        end
      end
      if (rd_en) begin
        if (first_rd < 0) first_rd = k;
        checks++;
        if (int'(rd_x) !== n_rd % W || int'(rd_y) !== n_rd / W) begin
          errors++;
          $display("FAIL %s read_coord got (%0d,%0d) exp (%0d,%0d)", name,
                   rd_x, rd_y, n_rd % W, n_rd / W);
        end
        e.x = n_rd % W;
        e.y = n_rd / W;
        e.v = exp_val(e.x, e.y);
        sb.push_back(e);
        n_rd++;
      end
      if (done) begin
        n_done++;
        done_at = k;
      end
    end
    checks += 7;
    if (n_rd !== N || first_rd !== 1) begin
      errors++;
      $display("FAIL %s reads got %0d@%0d exp %0d@1", name, n_rd, first_rd, N);
    end
    if (n_wr !== N) begin
      errors++;
      $display("FAIL %s write_count got %0d exp %0d", name, n_wr, N);
    end
    if (first_wr !== 2) begin
      errors++;
      $display("FAIL %s first_write got %0d exp 2", name, first_wr);
    end
    if (last_wr !== N + 1) begin
      errors++;
      $display("FAIL %s last_write got %0d exp %0d", name, last_wr, N + 1);
    end
    if (n_done !== 1) begin
      errors++;
      $display("FAIL %s done_count got %0d exp 1", name, n_done);
    end
    if (done_at !== N + 2) begin
      errors++;
      $display("FAIL %s done_cycle got %0d exp %0d", name, done_at, N + 2);
    end
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL %s pending_writes got %0d exp 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, done, rd_en, wr_en, rd_x, rd_y, wr_x, wr_y, wr_data} !== '0) begin
      errors++;
      $display("FAIL reset outputs got %h exp 0",
               {busy, done, rd_en, wr_en, rd_x, rd_y, wr_x, wr_y, wr_data});
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      checks++;
      if ((busy | done | rd_en | wr_en) !== 1'b0) begin
        errors++;
        $display("FAIL reset idle got %b%b%b%b exp 0000", busy, done, rd_en, wr_en);
      end
    end
  endtask

  task automatic test_identity();
    mode = 1;
    load_image(1);
    kern = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    load_kernel();
    run_frame("identity", 0, 0);
  endtask

  task automatic test_ones();
    mode = 2;
    load_image(2);
    kern = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    load_kernel();
    run_frame("ones", 0, 0);
  endtask

  task automatic test_sobel();
    mode = 3;
    load_image(3);
    kern = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    load_kernel();
    run_frame("sobel", 0, 0);
  endtask

  task automatic test_extreme();
    mode = 4;
    load_image(4);
    kern = '{7, 7, 7, 7, 7, 7, 7, 7, 7};
    load_kernel();
    run_frame("extreme", 0, 0);
  endtask

  task automatic test_restart_ignored();
    mode = 1;
    load_image(1);
    kern = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    load_kernel();
    run_frame("restart", 5, 0);
  endtask

  task automatic test_abort();
    mode = 1;
    load_image(1);
    kern = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    load_kernel();
    run_frame("abort", 0, 8);
    run_frame("after_abort", 0, 0);
  endtask

  initial begin
    mode = 1;
    load_image(1);
    test_reset();
    test_identity();
    test_ones();
    test_sobel();
    test_extreme();
    test_restart_ignored();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/win_conv_engine.md
Name: win_conv_engine

Overview:
- Initiator for the frame buffer's window read port, and writer into a second (output) frame buffer's pixel write port.
- On `start`, raster-scans every pixel of the source image and issues one window read per cycle.
- Convolves each WIN_HT x WIN_WD window with a runtime kernel and writes one result pixel per cycle at the same coordinates.
- Sits between the input frame buffer and the output frame buffer of the edge-detector pipeline.

Parameters:
- IMG_WD, 16: image width in pixels.
- IMG_HT, 16: image height in pixels.
- COORD_BITS, 4: coordinate width; must address max(IMG_WD, IMG_HT)-1.
- WIN_WD, 3: window width; odd.
- WIN_HT, 3: window height; odd.
- PXL_BITS, 12: signed pixel width.
- COEF_BITS, 4: signed kernel coefficient width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a frame scan when idle
- kernel_flat  in  WIN_HT*WIN_WD*COEF_BITS  signed coefficients; row-major, entry [y][x] at bit offset (y*WIN_WD+x)*COEF_BITS; must be held stable while busy
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the last write
- rd_en  out  1  window read request to the source frame buffer
- rd_x, rd_y  out  COORD_BITS each  centre coordinates of the window
- rd_data_flat  in  WIN_HT*WIN_WD*PXL_BITS  window returned combinationally by the source buffer, same layout as kernel_flat
- wr_en  out  1  write strobe to the output frame buffer
- wr_x, wr_y  out  COORD_BITS each  write coordinates
- wr_data_pxl  out  PXL_BITS  signed convolution result

Behaviour:
- Reset values: all outputs 0; FSM in IDLE. Reset asserted mid-scan aborts immediately: no further writes, no done pulse.
- FSM states:
  - IDLE: start=1 -> SCAN with x=0, y=0. Any other input stays in IDLE.
  - SCAN: each cycle, rd_en=1 with the current (x, y), all registered outputs. x increments and wraps to 0 at IMG_WD-1, then y increments. After the read at (IMG_WD-1, IMG_HT-1) -> DRAIN.
  - DRAIN: rd_en=0; waits one cycle for the final write -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- busy = (state != IDLE).
- start is ignored while busy; it must not restart or perturb the scan.
- Read data is sampled in the same cycle rd_en=1, because the buffer is combinational. The sum of products is registered together with the coordinates.
- wr_en/wr_x/wr_y/wr_data_pxl appear exactly 1 cycle after the matching rd_en. Throughput is 1 pixel/cycle with no bubbles.
- Frame timing: start at cycle 0 -> rd_en in cycles 1..N, wr_en in cycles 2..N+1, done in cycle N+2, where N = IMG_WD*IMG_HT.
- rd_x/rd_y and wr_x/wr_y hold their last values when their enables are low.
- Arithmetic: products are signed PXL_BITS x COEF_BITS. Accumulator width is PXL_BITS + COEF_BITS + clog2(WIN_WD*WIN_HT), so it never overflows.
- Result narrowing to PXL_BITS is governed by the optional feature below.
- Edge and corner handling belongs to the source buffer; this block always requests in-range centres.

Optional Feature:
- Macro: CONV_SAT_EN.
- Defined: result saturates to [-2^(PXL_BITS-1), 2^(PXL_BITS-1)-1].
- Undefined: result is the low PXL_BITS bits of the accumulator (two's-complement wrap).

Decomposition:
- Shared package `img_pkg`: IMG_WD/IMG_HT/PXL_BITS defaults, accumulator-width function, flat-index helper function (y, x, elem_bits) used by both buffer and engine.
- One sub-module: `win_mac`, a combinational WIN_HT*WIN_WD signed multiply-accumulate with the CONV_SAT_EN narrowing. The engine holds the FSM, counters and pipeline register.

Test Plan:
1. 4x4 ramp image (pixel = 4y+x), identity kernel (centre 1, others 0) -> output buffer equals input; wr_en cycles 2..17; done at cycle 18.
2. All-ones image, all-ones 3x3 kernel -> every output pixel 9, corners included (edge duplication by the buffer).
3. Vertical step image (x<2 -> 0, x>=2 -> 100), Sobel-X kernel [-1 0 1; -2 0 2; -1 0 1] -> 400 at columns 1..2, 0 at columns 0 and 3.
4. All pixels 2047, all coefficients 7 -> 1985 without CONV_SAT_EN (wrap of 128961); 2047 with CONV_SAT_EN.
5. Pulse start again at cycle 5 of a scan -> ignored; write sequence and done timing unchanged.
6. Deassert rst_n at cycle 8 -> all outputs 0 asynchronously; no done pulse. A fresh start after release runs a complete frame.
